// File: rtl/image_stream_arbiter.sv
// Round-robin arbiter that hands one windower input to NO_SRC image sources, one whole image at a time.
// Optional macro IMG_ARB_CHECK_EN adds a sticky err output and forces invalid beats to zero.
//
// state  | meaning
// IDLE   | waiting for a request while downstream is ready
// STREAM | granted source is read every cycle for 2^LOG2_IMG_SIZE beats
// GAP    | MIN_GAP idle cycles so the windower can flush its padding
module image_stream_arbiter #(
    parameter int NO_SRC        = 4,
    parameter int NO_CH         = 2,
    parameter int LOG2_IMG_SIZE = 10,
    parameter int THROUGHPUT    = 1,
    parameter int MIN_GAP       = 2
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic [NO_SRC-1:0]                            src_req,
    input  logic [NO_SRC-1:0]                            src_vld,
    input  logic [NO_SRC*THROUGHPUT-1:0][NO_CH-1:0]      src_data,
    input  logic                                         dn_rdy,
    output logic [NO_SRC-1:0]                            src_grant,
    output logic                                         src_rd,
    output logic                                         vld_out,
    output logic [THROUGHPUT-1:0][NO_CH-1:0]             data_out,
    output logic [$clog2(NO_SRC)-1:0]                    img_src,
    output logic                                         img_first,
    output logic                                         img_last,
    output logic                                         busy
`ifdef IMG_ARB_CHECK_EN
    ,
    output logic                                         err
`endif
);

    localparam int SRC_W = $clog2(NO_SRC);
    localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
    localparam logic [SRC_W-1:0] LAST_IDX = SRC_W'(NO_SRC - 1);
    localparam logic [SRC_W:0]   NO_SRC_W = (SRC_W + 1)'(NO_SRC);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((MIN_GAP > 0) ? MIN_GAP - 1 : 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        GAP    = 2'd2
    } state_t;

    state_t state, state_next;

    logic [SRC_W-1:0]          last_grant;
    logic [LOG2_IMG_SIZE-1:0]  beat_cnt;
    logic [GAP_W-1:0]          gap_cnt;
    logic                      last_beat;
    logic                      start_img;

    logic [SRC_W-1:0]          rr_ptr;
    logic [2*NO_SRC-1:0]       req_dbl;
    logic [NO_SRC-1:0]         req_rot;
    logic [SRC_W-1:0]          win_off;
    logic [SRC_W:0]            win_sum;
    logic [SRC_W-1:0]          win_idx;
    logic [NO_SRC-1:0]         win_oh;

    logic [THROUGHPUT-1:0][NO_CH-1:0] sel_data;
    logic [THROUGHPUT-1:0][NO_CH-1:0] beat_data;

    assign last_beat = (beat_cnt == '1);
    assign src_rd    = (state == STREAM);
    assign busy      = (state != IDLE);

    // Rotate the request vector so the search always starts at last_grant+1.
    always_comb begin
        rr_ptr  = (last_grant == LAST_IDX) ? '0 : last_grant + 1'b1;
        req_dbl = {src_req, src_req} >> rr_ptr;
        req_rot = req_dbl[NO_SRC-1:0];
        win_off = '0;
        for (int o = NO_SRC - 1; o >= 0; o--) begin
            if (req_rot[o]) begin
                win_off = SRC_W'(o);
            end
        end
        win_sum = {1'b0, rr_ptr} + {1'b0, win_off};
        if (win_sum >= NO_SRC_W) begin
            win_sum = win_sum - NO_SRC_W;
        end
        win_idx = win_sum[SRC_W-1:0];
        win_oh  = {{(NO_SRC-1){1'b0}}, 1'b1} << win_idx;
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NO_SRC; i++) begin
            if (src_grant[i]) begin
                sel_data = src_data[i*THROUGHPUT +: THROUGHPUT];
            end
        end
    end

`ifdef IMG_ARB_CHECK_EN
    logic sel_vld;
    logic win_req;

    assign sel_vld   = |(src_vld & src_grant);
    assign win_req   = |(src_req & win_oh);
    // A missing beat is replaced by zero so the windower still sees a full image.
    assign beat_data = sel_vld ? sel_data : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if ((state == STREAM && !sel_vld) || (start_img && !win_req)) begin
            err <= 1'b1;
        end
    end
`else
    logic unused_src_vld;

    assign unused_src_vld = ^src_vld;
    assign beat_data      = sel_data;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start_img  = 1'b0;
        case (state)
            IDLE: begin
                if ((|src_req) && dn_rdy) begin
                    state_next = STREAM;
                    start_img  = 1'b1;
                end
            end
            STREAM: begin
                if (last_beat) begin
                    state_next = (MIN_GAP > 0) ? GAP : IDLE;
                end
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            src_grant  <= '0;
            img_src    <= '0;
            last_grant <= LAST_IDX;
            beat_cnt   <= '0;
            gap_cnt    <= '0;
            vld_out    <= 1'b0;
            img_first  <= 1'b0;
            img_last   <= 1'b0;
            data_out   <= '0;
        end else begin
            vld_out   <= 1'b0;
            img_first <= 1'b0;
            img_last  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_img) begin
                        src_grant  <= win_oh;
                        img_src    <= win_idx;
                        last_grant <= win_idx;
                        beat_cnt   <= '0;
                    end
                end
                STREAM: begin
                    vld_out   <= 1'b1;
                    data_out  <= beat_data;
                    img_first <= (beat_cnt == '0);
                    img_last  <= last_beat;
                    beat_cnt  <= beat_cnt + 1'b1;
                    if (last_beat) begin
                        src_grant <= '0;
                        gap_cnt   <= GAP_LOAD;
                    end
                end
                GAP: begin
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                    src_grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/image_stream_arbiter.md
Name: image_stream_arbiter

Overview:
- Shares one windower input between NO_SRC image sources, such as per-channel capture buffers.
- Grants one source per image, round-robin, and streams exactly 2^LOG2_IMG_SIZE contiguous beats.
- The contiguous stream is required because the windower has no backpressure and expects the whole image once vld_in rises.
- Inserts a configurable idle gap between images so the windower can flush its end-of-image padding.

Parameters:
NO_SRC, 4, number of requesting sources (>=2)
NO_CH, 2, bits per sample
LOG2_IMG_SIZE, 10, log2 of beats per image
THROUGHPUT, 1, samples per beat (power of 2)
MIN_GAP, 2, extra idle cycles after each image (>=0)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
src_req  in  NO_SRC  source i holds a complete image ready to stream
src_vld  in  NO_SRC  source i data valid this cycle
src_data  in  [NO_CH-1:0] x [NO_SRC*THROUGHPUT-1:0]  source i occupies entries i*THROUGHPUT+THROUGHPUT-1 .. i*THROUGHPUT
dn_rdy  in  1  downstream can accept a new image
src_grant  out  NO_SRC  one-hot grant, held for the whole image
src_rd  out  1  beat strobe to the granted source; data consumed this cycle
vld_out  out  1  to windower vld_in
data_out  out  [NO_CH-1:0] x [THROUGHPUT-1:0]  to windower data_in
img_src  out  $clog2(NO_SRC)  index of the source of the current image
img_first  out  1  qualifies first beat of an image (with vld_out)
img_last  out  1  qualifies last beat of an image (with vld_out)
busy  out  1  state != IDLE

Behaviour:
- Clock and reset: single clock domain; reset is synchronous, active-low.
- States: IDLE, STREAM, GAP.
- IDLE:
  - If |src_req && dn_rdy, pick the winner round-robin, starting at (last_grant+1) mod NO_SRC.
  - Register src_grant (one-hot), img_src and last_grant; clear beat_cnt; go to STREAM.
  - Otherwise stay in IDLE.
- STREAM:
  - src_rd = 1 combinationally (state==STREAM). src_grant is stable.
  - Each cycle: data_out <= granted slice of src_data; vld_out <= 1; img_first <= (beat_cnt==0); img_last <= (beat_cnt==2^LOG2_IMG_SIZE-1); beat_cnt <= beat_cnt+1.
  - beat_cnt is LOG2_IMG_SIZE bits and wraps to 0 on the last beat.
  - On the last beat: src_grant <= 0; go to GAP if MIN_GAP>0, else IDLE.
- GAP: vld_out=0; count MIN_GAP cycles, then go to IDLE.
- Latency:
  - vld_out/data_out lag src_rd by exactly 1 cycle.
  - First vld_out appears 2 cycles after the request is seen in IDLE.
  - Between images: exactly MIN_GAP+1 cycles with vld_out=0.
- Outside STREAM+1: vld_out, img_first, img_last are 0 and data_out holds its last value.
- src_req and dn_rdy are sampled only in IDLE. Deasserting them during STREAM or GAP has no effect; an image is never truncated.
- Simultaneous requests are resolved strictly by rotating priority, so no source is served twice while another requester waits.
- An NO_SRC not a power of 2 is legal. The round-robin index wraps mod NO_SRC.
- Reset (any state, including mid-image):
  - Next state is IDLE.
  - src_grant=0, src_rd=0, vld_out=0, img_first=0, img_last=0, data_out=0, img_src=0.
  - beat_cnt=0, gap counter=0.
  - last_grant=NO_SRC-1, so source 0 wins first.
  - The downstream windower must be reset with the same rst_n.

Optional Feature:
Macro IMG_ARB_CHECK_EN.
- Defined:
  - Extra output err (1 bit, reset 0), sticky until reset.
  - err sets on any STREAM cycle where src_vld[granted]==0.
  - That beat's data_out is forced to 0 while vld_out stays 1, which preserves the windower beat count.
  - err also sets if src_req[granted] is low in the IDLE->STREAM transition cycle (impossible by construction; included as a sanity check).
- Not defined: no err port; src_vld is ignored; data passes unchanged.

Test Plan:
Use LOG2_IMG_SIZE=3, NO_SRC=4, MIN_GAP=2, THROUGHPUT=1 unless stated.
- Single source: src_req=4'b0001, dn_rdy=1, src_data=beat index -> src_grant=0001 for 8 cycles; vld_out high 8 cycles carrying 0..7; img_first on beat 0, img_last on beat 7; then 3 idle cycles.
- All four sources request continuously -> images served in order 0,1,2,3,0; img_src matches; each image is 8 contiguous vld_out cycles separated by exactly 3 zero cycles.
- dn_rdy=0 with src_req=0010 -> no grant, busy=0. Raising dn_rdy at cycle T -> src_grant=0010 at T+1, first vld_out at T+2.
- Drop src_req and dn_rdy at beat 3 of an image -> all 8 beats still delivered; no new image starts afterwards.
- Assert rst_n=0 for 1 cycle at beat 5 -> next cycle all outputs 0 and state IDLE; the next grant goes to source 0 regardless of the previous grantee.
- IMG_ARB_CHECK_EN defined, src_vld[granted]=0 on beat 4 -> data_out=0 on that beat, vld_out still 1, err=1 and held until reset. Macro undefined -> beat passes unchanged.
